y_sram_arbiter: RTL

Shares the two read ports and the single write port of the Y SRAM (256-bit rows, 11-bit row address) among up to N_REQ read requesters and one row-update writer. It sits between the compute/update units and `y_sram`, and is the only block that drives Y SRAM addresses and WE. Each cycle it grants up to two reads, round-robin and starvation-free. It blocks reads that collide with a same-cycle write and routes read data back to the owner, tagged, after the SRAM read latency.

---
 rtl/y_sram_pkg.sv | 16 +
 rtl/y_sram_arbiter_rr_pick2.sv | 42 ++++
 rtl/y_sram_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/y_sram_pkg.sv
// Shared Y SRAM definitions: default geometry and the per-port read tag.
package y_sram_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 256;
  localparam int unsigned DEPTH_DEF  = 2048;
  localparam int unsigned IDX_W      = 3;

  // Travels alongside each issued read until its data returns.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             err;
  } tag_t;

endpackage

// File: rtl/y_sram_arbiter_rr_pick2.sv
// Two-winner round-robin picker: scans eligibility from ptr, first hit to port 1, second to port 2.
module rr_pick2 #(
  parameter int unsigned N = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt1,
  output logic [N-1:0]  gnt2,
  output logic [PW-1:0] ptr_next
);

  always_comb begin
    logic          found1;
    logic          found2;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    gnt1     = '0;
    gnt2     = '0;
    ptr_next = ptr;
    found1   = 1'b0;
    found2   = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      // The pointer always follows the most recent winner in scan order.
      if (elig[idx] && !found1) begin
        gnt1[idx] = 1'b1;
        found1    = 1'b1;
        ptr_next  = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
      end else if (elig[idx] && !found2) begin
        gnt2[idx] = 1'b1;
        found2    = 1'b1;
        ptr_next  = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
      end
    end
  end

endmodule

// File: rtl/y_sram_arbiter.sv
// Y SRAM port arbiter: write priority, two round-robin read grants per cycle, tagged response routing.
module y_sram_arbiter
  import y_sram_pkg::*;
#(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          rd_req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   rd_req_addr,
  output logic [N_REQ-1:0]          rd_req_ready,
  output logic [N_REQ-1:0]          rd_rsp_valid,
  output logic [N_REQ-1:0]          rd_rsp_err,
  output logic [N_REQ*DATA_W-1:0]   rd_rsp_data,
  input  logic                      wr_req_valid,
  input  logic [ADDR_W-1:0]         wr_req_addr,
  input  logic [DATA_W-1:0]         wr_req_data,
  output logic                      wr_req_ready,
  output logic                      sram_we,
  output logic [ADDR_W-1:0]         sram_waddr,
  output logic [DATA_W-1:0]         sram_wdata,
  output logic [ADDR_W-1:0]         sram_raddr1,
  output logic [ADDR_W-1:0]         sram_raddr2,
  input  logic [DATA_W-1:0]         sram_rdata1,
  input  logic [DATA_W-1:0]         sram_rdata2
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= (ADDR_W+1)'(DEPTH);
  endfunction

  logic                wr_fire;
  logic [N_REQ-1:0]    elig;
  logic [N_REQ-1:0]    gnt1;
  logic [N_REQ-1:0]    gnt2;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       ptr_next;
  logic [ADDR_W-1:0]   sel_addr   [2];
  logic [IDX_W-1:0]    sel_idx    [2];
  logic [ADDR_W-1:0]   issue_addr [2];
  logic [ADDR_W-1:0]   last_addr  [2];
  tag_t                issue_tag  [2];
  tag_t                pipe       [2][RD_LAT];
  logic [DATA_W-1:0]   rdata      [2];

  assign wr_req_ready = reset;
  assign wr_fire      = wr_req_valid && reset;
  assign sram_we      = wr_fire && !out_of_range(wr_req_addr);
  assign sram_waddr   = wr_req_addr;
  assign sram_wdata   = wr_req_data;
  assign rdata[0]     = sram_rdata1;
  assign rdata[1]     = sram_rdata2;

  // A read to the row being written this cycle waits so it sees the new data.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = reset && rd_req_valid[i] &&
                !(wr_fire && (rd_req_addr[i*ADDR_W +: ADDR_W] == wr_req_addr));
    end
  end

  rr_pick2 #(.N(N_REQ)) u_pick (
    .elig     (elig),
    .ptr      (rr_ptr),
    .gnt1     (gnt1),
    .gnt2     (gnt2),
    .ptr_next (ptr_next)
  );

  assign rd_req_ready = gnt1 | gnt2;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      sel_addr[p] = '0;
      sel_idx[p]  = '0;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt1[i]) begin
        sel_addr[0] = rd_req_addr[i*ADDR_W +: ADDR_W];
        sel_idx[0]  = IDX_W'(i);
      end
      if (gnt2[i]) begin
        sel_addr[1] = rd_req_addr[i*ADDR_W +: ADDR_W];
        sel_idx[1]  = IDX_W'(i);
      end
    end
    // Out-of-range grants still occupy the port but read row 0.
    for (int unsigned p = 0; p < 2; p++) begin
      issue_tag[p].valid = (p == 0) ? |gnt1 : |gnt2;
      issue_tag[p].idx   = sel_idx[p];
      issue_tag[p].err   = out_of_range(sel_addr[p]);
      issue_addr[p]      = issue_tag[p].err ? '0 : sel_addr[p];
    end
  end

  assign sram_raddr1 = !reset ? '0 : (issue_tag[0].valid ? issue_addr[0] : last_addr[0]);
  assign sram_raddr2 = !reset ? '0 : (issue_tag[1].valid ? issue_addr[1] : last_addr[1]);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        last_addr[p] <= '0;
        for (int unsigned j = 0; j < RD_LAT; j++) pipe[p][j] <= '0;
      end
    end else begin
      rr_ptr <= ptr_next;
      for (int unsigned p = 0; p < 2; p++) begin
        if (issue_tag[p].valid) last_addr[p] <= issue_addr[p];
        pipe[p][0] <= issue_tag[p];
        for (int unsigned j = 1; j < RD_LAT; j++) pipe[p][j] <= pipe[p][j-1];
      end
    end
  end

  // Pipeline heads line up with the SRAM read data of the same port.
  always_comb begin
    rd_rsp_valid = '0;
    rd_rsp_err   = '0;
    rd_rsp_data  = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (reset && pipe[p][RD_LAT-1].valid && (pipe[p][RD_LAT-1].idx == IDX_W'(i))) begin
          rd_rsp_valid[i]                 = 1'b1;
          rd_rsp_err[i]                   = pipe[p][RD_LAT-1].err;
          rd_rsp_data[i*DATA_W +: DATA_W] = pipe[p][RD_LAT-1].err ? '0 : rdata[p];
        end
      end
    end
  end

endmodule
